// File: rtl/scratchpad_req_decoder.sv
// Scratchpad request decoder.
// Pops entries from the execute-to-scratchpad request FIFO and decodes each one.
// A matrix load/store entry becomes ROWS per-row scratchpad requests.
// A GEMM entry becomes a single dispatch to the systolic-array controller.
// An entry with an illegal opcode is dropped and flagged with a one-cycle pulse.
module scratchpad_req_decoder #(
  parameter int ROWS      = 4,
  parameter int ROW_BYTES = 16,
  parameter int ROW_W     = 2
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             fifo_empty,
  input  logic [37:0]      fifo_rdata,
  output logic             fifo_ren,
  output logic             sp_req_valid,
  input  logic             sp_req_ready,
  output logic             sp_req_wen,
  output logic [3:0]       sp_req_matrix,
  output logic [ROW_W-1:0] sp_req_row,
  output logic [31:0]      sp_req_addr,
  output logic             gemm_valid,
  input  logic             gemm_ready,
  output logic             gemm_new_weight,
  output logic [3:0]       gemm_rs1,
  output logic [3:0]       gemm_rs2,
  output logic [3:0]       gemm_rs3,
  output logic [3:0]       gemm_rd,
  output logic             busy,
  output logic             err_illegal
);

  localparam logic [1:0]       OP_LOAD    = 2'b01;
  localparam logic [1:0]       OP_STORE   = 2'b10;
  localparam logic [1:0]       OP_GEMM    = 2'b11;
  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(ROWS - 1);
  localparam logic [31:0]      ROW_STRIDE = 32'(ROW_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    MLS,
    GEMM
  } state_t;

  state_t state;

  logic [1:0]  head_op;
  logic [3:0]  head_matrix;
  logic [31:0] head_base;
  logic        head_new_weight;
  logic [3:0]  head_rs1;
  logic [3:0]  head_rs2;
  logic [3:0]  head_rs3;
  logic [3:0]  head_rd;
  logic [18:0] gemm_unused_bits;

  assign head_op          = fifo_rdata[37:36];
  assign head_matrix      = fifo_rdata[35:32];
  assign head_base        = fifo_rdata[31:0];
  assign head_new_weight  = fifo_rdata[35];
  assign head_rs1         = fifo_rdata[15:12];
  assign head_rs2         = fifo_rdata[11:8];
  assign head_rs3         = fifo_rdata[7:4];
  assign head_rd          = fifo_rdata[3:0];
  assign gemm_unused_bits = fifo_rdata[34:16];

  // The head entry is popped in the same cycle it is decoded, only from IDLE
  // and never while reset is held.
  assign fifo_ren = (state == IDLE) && !fifo_empty && nRST;
  assign busy     = (state != IDLE);

  // Decode FSM: latches the popped entry into registered request outputs,
  // steps through the tile rows, and holds each request until it is accepted.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state           <= IDLE;
      sp_req_valid    <= 1'b0;
      sp_req_wen      <= 1'b0;
      sp_req_matrix   <= '0;
      sp_req_row      <= '0;
      sp_req_addr     <= '0;
      gemm_valid      <= 1'b0;
      gemm_new_weight <= 1'b0;
      gemm_rs1        <= '0;
      gemm_rs2        <= '0;
      gemm_rs3        <= '0;
      gemm_rd         <= '0;
      err_illegal     <= 1'b0;
    end else begin
      err_illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            case (head_op)
              OP_LOAD, OP_STORE: begin
                state         <= MLS;
                sp_req_valid  <= 1'b1;
                sp_req_wen    <= (head_op == OP_STORE);
                sp_req_matrix <= head_matrix;
                sp_req_row    <= '0;
                sp_req_addr   <= head_base;
              end
              OP_GEMM: begin
                state           <= GEMM;
                gemm_valid      <= 1'b1;
                gemm_new_weight <= head_new_weight;
                gemm_rs1        <= head_rs1;
                gemm_rs2        <= head_rs2;
                gemm_rs3        <= head_rs3;
                gemm_rd         <= head_rd;
              end
              default: begin
                err_illegal <= 1'b1;
              end
            endcase
          end
        end
        MLS: begin
          if (sp_req_ready) begin
            if (sp_req_row == LAST_ROW) begin
              state         <= IDLE;
              sp_req_valid  <= 1'b0;
              sp_req_wen    <= 1'b0;
              sp_req_matrix <= '0;
              sp_req_row    <= '0;
              sp_req_addr   <= '0;
            end else begin
              sp_req_row  <= sp_req_row + ROW_W'(1);
              sp_req_addr <= sp_req_addr + ROW_STRIDE;
            end
          end
        end
        GEMM: begin
          if (gemm_ready) begin
            state           <= IDLE;
            gemm_valid      <= 1'b0;
            gemm_new_weight <= 1'b0;
            gemm_rs1        <= '0;
            gemm_rs2        <= '0;
            gemm_rs3        <= '0;
            gemm_rd         <= '0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scratchpad_req_decoder.sv
// Testbench for scratchpad_req_decoder.
// A queue models the request FIFO. Every popped entry is expanded into the list
// of transactions it should produce, and a negedge scoreboard compares the
// DUT's requests, busy flag, pop strobe and error pulse against that list.
module tb_scratchpad_req_decoder;

  localparam int ROWS      = 4;
  localparam int ROW_BYTES = 16;
  localparam int ROW_W     = 2;

  logic             CLK = 1'b0;
  logic             nRST = 1'b0;
  logic             fifo_empty = 1'b1;
  logic [37:0]      fifo_rdata = '0;
  logic             fifo_ren;
  logic             sp_req_valid;
  logic             sp_req_ready = 1'b0;
  logic             sp_req_wen;
  logic [3:0]       sp_req_matrix;
  logic [ROW_W-1:0] sp_req_row;
  logic [31:0]      sp_req_addr;
  logic             gemm_valid;
  logic             gemm_ready = 1'b0;
  logic             gemm_new_weight;
  logic [3:0]       gemm_rs1;
  logic [3:0]       gemm_rs2;
  logic [3:0]       gemm_rs3;
  logic [3:0]       gemm_rd;
  logic             busy;
  logic             err_illegal;

  scratchpad_req_decoder #(
    .ROWS(ROWS), .ROW_BYTES(ROW_BYTES), .ROW_W(ROW_W)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_ren(fifo_ren),
    .sp_req_valid(sp_req_valid), .sp_req_ready(sp_req_ready),
    .sp_req_wen(sp_req_wen), .sp_req_matrix(sp_req_matrix),
    .sp_req_row(sp_req_row), .sp_req_addr(sp_req_addr),
    .gemm_valid(gemm_valid), .gemm_ready(gemm_ready),
    .gemm_new_weight(gemm_new_weight), .gemm_rs1(gemm_rs1),
    .gemm_rs2(gemm_rs2), .gemm_rs3(gemm_rs3), .gemm_rd(gemm_rd),
    .busy(busy), .err_illegal(err_illegal)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit               is_gemm;
    bit               wen;
    logic [3:0]       matrix;
    logic [ROW_W-1:0] row;
    logic [31:0]      addr;
    bit               nw;
    logic [3:0]       rs1;
    logic [3:0]       rs2;
    logic [3:0]       rs3;
    logic [3:0]       rd;
  } txn_t;

  txn_t        exp_q[$];
  logic [37:0] fifo_q[$];
  int          total = 0;
  int          bad = 0;
  int          pop_count = 0;
  int          hs_count = 0;
  int          err_seen = 0;
  bit          mon_en = 1'b0;
  bit          pop_seen = 1'b0;
  bit          illegal_due = 1'b0;
  bit          exp_sp, exp_g, exp_busy, exp_ren;

  // Expand one popped entry into the transactions it must produce.
  task automatic model_pop(input logic [37:0] e);
    txn_t t;
    t = '{default: '0};
    case (e[37:36])
      2'b01, 2'b10: begin
        for (int r = 0; r < ROWS; r++) begin
          t.is_gemm = 1'b0;
          t.wen     = (e[37:36] == 2'b10);
          t.matrix  = e[35:32];
          t.row     = ROW_W'(r);
          t.addr    = e[31:0] + 32'(r * ROW_BYTES);
          exp_q.push_back(t);
        end
      end
      2'b11: begin
        t.is_gemm = 1'b1;
        t.nw      = e[35];
        t.rs1     = e[15:12];
        t.rs2     = e[11:8];
        t.rs3     = e[7:4];
        t.rd      = e[3:0];
        exp_q.push_back(t);
      end
      default: illegal_due = 1'b1;
    endcase
  endtask

  task automatic refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_rdata = (fifo_q.size() == 0) ? 38'd0 : fifo_q[0];
  endtask

  task automatic push(input logic [37:0] e);
    fifo_q.push_back(e);
    refresh();
  endtask

  // Advance one clock and retire the FIFO head if the DUT popped it.
  task automatic tick();
    @(posedge CLK);
    #1;
    if (pop_seen) begin
      void'(fifo_q.pop_front());
      pop_seen = 1'b0;
    end
    refresh();
  endtask

  // Scoreboard: compares DUT behaviour with the outstanding transaction list.
  always @(negedge CLK) begin
    if (mon_en && nRST) begin
      exp_busy = (exp_q.size() != 0);
      exp_sp   = (exp_q.size() != 0) && !exp_q[0].is_gemm;
      exp_g    = (exp_q.size() != 0) && exp_q[0].is_gemm;
      exp_ren  = !fifo_empty && (exp_q.size() == 0);

      total++;
      if (busy !== exp_busy) begin
        bad++;
        $display("[TB] FAIL busy got=%b want=%b t=%0t", busy, exp_busy, $time);
      end
      total++;
      if (sp_req_valid !== exp_sp) begin
        bad++;
        $display("[TB] FAIL sp_valid got=%b want=%b t=%0t", sp_req_valid, exp_sp, $time);
      end
      total++;
      if (gemm_valid !== exp_g) begin
        bad++;
        $display("[TB] FAIL gemm_valid got=%b want=%b t=%0t", gemm_valid, exp_g, $time);
      end
      total++;
      if (fifo_ren !== exp_ren) begin
        bad++;
        $display("[TB] FAIL fifo_ren got=%b want=%b t=%0t", fifo_ren, exp_ren, $time);
      end
      total++;
      if (err_illegal !== illegal_due) begin
        bad++;
        $display("[TB] FAIL err_illegal got=%b want=%b t=%0t", err_illegal, illegal_due, $time);
      end
      if (err_illegal === 1'b1) err_seen++;
      illegal_due = 1'b0;

      if (exp_sp && sp_req_valid) begin
        total++;
        if ({sp_req_wen, sp_req_matrix, sp_req_row, sp_req_addr} !==
            {exp_q[0].wen, exp_q[0].matrix, exp_q[0].row, exp_q[0].addr}) begin
          bad++;
          $display("[TB] FAIL sp_fields got wen=%b m=%h row=%0d addr=%h want wen=%b m=%h row=%0d addr=%h",
                   sp_req_wen, sp_req_matrix, sp_req_row, sp_req_addr,
                   exp_q[0].wen, exp_q[0].matrix, exp_q[0].row, exp_q[0].addr);
        end
      end
      if (exp_g && gemm_valid) begin
        total++;
        if ({gemm_new_weight, gemm_rs1, gemm_rs2, gemm_rs3, gemm_rd} !==
            {exp_q[0].nw, exp_q[0].rs1, exp_q[0].rs2, exp_q[0].rs3, exp_q[0].rd}) begin
          bad++;
          $display("[TB] FAIL gemm_fields got nw=%b %h/%h/%h/%h want nw=%b %h/%h/%h/%h",
                   gemm_new_weight, gemm_rs1, gemm_rs2, gemm_rs3, gemm_rd,
                   exp_q[0].nw, exp_q[0].rs1, exp_q[0].rs2, exp_q[0].rs3, exp_q[0].rd);
        end
      end

      if ((exp_sp && sp_req_valid && sp_req_ready) || (exp_g && gemm_valid && gemm_ready)) begin
        void'(exp_q.pop_front());
        hs_count++;
      end
      if (fifo_ren === 1'b1) begin
        pop_seen = 1'b1;
        pop_count++;
        model_pop(fifo_rdata);
      end
    end
  end

  task automatic test_reset();
    nRST   = 1'b0;
    mon_en = 1'b0;
    push({2'b01, 4'h1, 32'h0000_0100});
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    total++;
    if (fifo_ren !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_fifo_ren got=%b want=0", fifo_ren);
    end
    total++;
    if ({busy, sp_req_valid, gemm_valid, err_illegal} !== 4'b0000) begin
      bad++; $display("[TB] FAIL reset_flags got=%b want=0000", {busy, sp_req_valid, gemm_valid, err_illegal});
    end
    total++;
    if ({sp_req_wen, sp_req_matrix, sp_req_row, sp_req_addr} !== '0) begin
      bad++; $display("[TB] FAIL reset_sp_fields got addr=%h row=%0d want 0", sp_req_addr, sp_req_row);
    end
    total++;
    if ({gemm_new_weight, gemm_rs1, gemm_rs2, gemm_rs3, gemm_rd} !== '0) begin
      bad++; $display("[TB] FAIL reset_gemm_fields got rs1=%h rd=%h want 0", gemm_rs1, gemm_rd);
    end
    fifo_q.delete();
    refresh();
    nRST   = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_load();
    logic [31:0] la [4] = '{32'h1000, 32'h1010, 32'h1020, 32'h1030};
    int p0;
    tick();
    sp_req_ready = 1'b1;
    p0 = pop_count;
    push({2'b01, 4'h3, 32'h0000_1000});
    @(negedge CLK);
    total++;
    if (fifo_ren !== 1'b1) begin
      bad++; $display("[TB] FAIL load_pop got=%b want=1", fifo_ren);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge CLK);
      total++;
      if ({sp_req_valid, sp_req_wen, sp_req_matrix, sp_req_row, sp_req_addr} !==
          {1'b1, 1'b0, 4'h3, ROW_W'(k), la[k]}) begin
        bad++;
        $display("[TB] FAIL load_row%0d got v=%b wen=%b m=%h row=%0d addr=%h want v=1 wen=0 m=3 row=%0d addr=%h",
                 k, sp_req_valid, sp_req_wen, sp_req_matrix, sp_req_row, sp_req_addr, k, la[k]);
      end
    end
    tick();
    @(negedge CLK);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("[TB] FAIL load_busy_drop got=%b want=0", busy);
    end
    total++;
    if (pop_count - p0 != 1) begin
      bad++; $display("[TB] FAIL load_pops got=%0d want=1", pop_count - p0);
    end
  endtask

  task automatic test_store_backpressure();
    bit rp [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int p0, h0;
    tick();
    sp_req_ready = 1'b1;
    p0 = pop_count;
    h0 = hs_count;
    push({2'b10, 4'hA, 32'h0000_2000});
    @(negedge CLK);
    for (int c = 1; c <= 7; c++) begin
      tick();
      sp_req_ready = rp[c-1];
      @(negedge CLK);
      if (c >= 2 && c <= 4) begin
        total++;
        if ({sp_req_valid, sp_req_wen, sp_req_matrix, sp_req_row, sp_req_addr} !==
            {1'b1, 1'b1, 4'hA, ROW_W'(1), 32'h0000_2010}) begin
          bad++;
          $display("[TB] FAIL store_hold c=%0d got v=%b wen=%b m=%h row=%0d addr=%h want v=1 wen=1 m=a row=1 addr=00002010",
                   c, sp_req_valid, sp_req_wen, sp_req_matrix, sp_req_row, sp_req_addr);
        end
      end
    end
    tick();
    @(negedge CLK);
    total++;
    if (hs_count - h0 != 4) begin
      bad++; $display("[TB] FAIL store_handshakes got=%0d want=4", hs_count - h0);
    end
    total++;
    if (pop_count - p0 != 1) begin
      bad++; $display("[TB] FAIL store_pops got=%0d want=1", pop_count - p0);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("[TB] FAIL store_idle got=%b want=0", busy);
    end
  endtask

  task automatic test_gemm();
    bit gp [3] = '{1'b0, 1'b0, 1'b1};
    int h0;
    tick();
    sp_req_ready = 1'b1;
    gemm_ready   = 1'b0;
    h0 = hs_count;
    push({2'b11, 1'b1, 19'h5_5555, 4'h1, 4'h2, 4'h3, 4'h4});
    @(negedge CLK);
    for (int c = 1; c <= 3; c++) begin
      tick();
      gemm_ready = gp[c-1];
      @(negedge CLK);
      total++;
      if ({gemm_valid, sp_req_valid, gemm_new_weight, gemm_rs1, gemm_rs2, gemm_rs3, gemm_rd} !==
          {1'b1, 1'b0, 1'b1, 4'h1, 4'h2, 4'h3, 4'h4}) begin
        bad++;
        $display("[TB] FAIL gemm_hold c=%0d got gv=%b sv=%b nw=%b %h/%h/%h/%h want gv=1 sv=0 nw=1 1/2/3/4",
                 c, gemm_valid, sp_req_valid, gemm_new_weight, gemm_rs1, gemm_rs2, gemm_rs3, gemm_rd);
      end
    end
    tick();
    gemm_ready = 1'b0;
    @(negedge CLK);
    total++;
    if ({gemm_valid, sp_req_valid, busy} !== 3'b000) begin
      bad++; $display("[TB] FAIL gemm_done got=%b want=000", {gemm_valid, sp_req_valid, busy});
    end
    total++;
    if (hs_count - h0 != 1) begin
      bad++; $display("[TB] FAIL gemm_handshakes got=%0d want=1", hs_count - h0);
    end
  endtask

  task automatic test_illegal_then_load();
    int p0, h0, e0;
    tick();
    sp_req_ready = 1'b1;
    p0 = pop_count;
    h0 = hs_count;
    e0 = err_seen;
    push({2'b00, 4'hF, 32'h1234_5678});
    push({2'b01, 4'h7, 32'h0000_0400});
    @(negedge CLK);
    tick();
    @(negedge CLK);
    total++;
    if ({err_illegal, sp_req_valid, fifo_ren} !== 3'b101) begin
      bad++; $display("[TB] FAIL illegal_pulse got=%b want=101", {err_illegal, sp_req_valid, fifo_ren});
    end
    repeat (6) begin
      tick();
      @(negedge CLK);
    end
    total++;
    if (err_seen - e0 != 1) begin
      bad++; $display("[TB] FAIL illegal_count got=%0d want=1", err_seen - e0);
    end
    total++;
    if (hs_count - h0 != 4) begin
      bad++; $display("[TB] FAIL illegal_load_hs got=%0d want=4", hs_count - h0);
    end
    total++;
    if (pop_count - p0 != 2) begin
      bad++; $display("[TB] FAIL illegal_pops got=%0d want=2", pop_count - p0);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] wa [4] = '{32'hFFFF_FFF0, 32'h0000_0000, 32'h0000_0010, 32'h0000_0020};
    tick();
    sp_req_ready = 1'b1;
    push({2'b01, 4'h0, 32'hFFFF_FFF0});
    @(negedge CLK);
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge CLK);
      total++;
      if (sp_req_addr !== wa[k]) begin
        bad++; $display("[TB] FAIL wrap_addr%0d got=%h want=%h", k, sp_req_addr, wa[k]);
      end
    end
    tick();
    @(negedge CLK);
  endtask

  task automatic test_random();
    int          n_push = 0;
    int          cycles = 0;
    int          p0;
    logic [1:0]  op;
    logic [37:0] e;
    p0 = pop_count;
    while ((n_push < 40 || fifo_q.size() != 0 || exp_q.size() != 0 || busy) && cycles < 3000) begin
      tick();
      cycles++;
      sp_req_ready = ($urandom_range(0, 3) != 0);
      gemm_ready   = ($urandom_range(0, 2) != 0);
      if (n_push < 40 && $urandom_range(0, 2) != 0) begin
        op = 2'($urandom_range(0, 3));
        e  = {op, 4'($urandom), 32'($urandom)};
        push(e);
        n_push++;
      end
      @(negedge CLK);
    end
    total++;
    if (cycles >= 3000) begin
      bad++; $display("[TB] FAIL random_timeout got=%0d cycles want<3000", cycles);
    end
    total++;
    if (pop_count - p0 != 40) begin
      bad++; $display("[TB] FAIL random_pops got=%0d want=40", pop_count - p0);
    end
    tick();
    sp_req_ready = 1'b0;
    gemm_ready   = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset_midburst();
    bit found = 1'b0;
    tick();
    sp_req_ready = 1'b1;
    push({2'b01, 4'h5, 32'h0000_3000});
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge CLK);
      if (sp_req_valid === 1'b1 && sp_req_row === ROW_W'(2)) found = 1'b1;
      else tick();
    end
    total++;
    if (!found) begin
      bad++; $display("[TB] FAIL midburst_row2 got=not_seen want=seen");
    end
    #2;
    nRST   = 1'b0;
    mon_en = 1'b0;
    #1;
    total++;
    if ({sp_req_valid, busy, fifo_ren, sp_req_row, sp_req_addr, sp_req_matrix} !== '0) begin
      bad++;
      $display("[TB] FAIL midburst_reset got v=%b busy=%b ren=%b row=%0d addr=%h m=%h want all 0",
               sp_req_valid, busy, fifo_ren, sp_req_row, sp_req_addr, sp_req_matrix);
    end
    fifo_q.delete();
    exp_q.delete();
    pop_seen     = 1'b0;
    illegal_due  = 1'b0;
    sp_req_ready = 1'b0;
    refresh();
    @(negedge CLK);
    nRST   = 1'b1;
    mon_en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      total++;
      if ({fifo_ren, busy, sp_req_valid} !== 3'b000) begin
        bad++; $display("[TB] FAIL post_reset_idle c=%0d got=%b want=000", c, {fifo_ren, busy, sp_req_valid});
      end
    end
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    test_reset();
    test_load();
    test_store_backpressure();
    test_gemm();
    test_illegal_then_load();
    test_wrap();
    test_random();
    test_reset_midburst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guards against a stalled run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
